// File: rtl/keypad_pkg.sv
// keypad_pkg: shared key-matrix geometry defaults and key indexing helper
package keypad_pkg;
  localparam int DEF_ROWS = 4;
  localparam int DEF_COLS = 4;
  localparam int KEY_W = $clog2(DEF_ROWS * DEF_COLS);
  function automatic int key_index(input int row, input int col, input int cols = DEF_COLS);
    return row * cols + col;
  endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: per-key debounce counter and accepted state bit
module key_debounce #(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sample_en,
  input  logic i_sample,
  input  logic i_commit,
  output logic o_state,
  output logic o_change_req
);
  localparam int CW = $clog2(DEBOUNCE_SCANS) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_SCANS - 1);
  logic [CW-1:0] r_cnt;
  logic r_state;
  logic w_diff;
  logic w_take;
  assign w_diff = i_sample != r_state;
  assign o_change_req = i_sample_en && w_diff && r_cnt == LAST;
  assign w_take = o_change_req && i_commit;
  assign o_state = r_state;
  // a request that loses priority holds the counter at LAST until the next visit
  always_ff @(posedge clk)
    if (rst) begin
      r_cnt <= '0;
      r_state <= 1'b0;
    end else if (i_sample_en) begin
      r_cnt <= (!w_diff || w_take) ? '0 : o_change_req ? r_cnt : r_cnt + 1'b1;
      if (w_take) r_state <= ~r_state;
    end
endmodule

// File: rtl/key_matrix_scanner.sv
// key_matrix_scanner: column-scanned key matrix with per-key debounce and press/release events
module key_matrix_scanner #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int SCAN_DIV = 10_000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ROWS-1:0]               row_in,
  output logic [COLS-1:0]               col_select,
  output logic [ROWS*COLS-1:0]          key_state,
  output logic [$clog2(ROWS*COLS)-1:0]  key_code,
  output logic                          key_pressed,
  output logic                          key_released,
  output logic                          any_pressed
);
  import keypad_pkg::*;
  localparam int NK = ROWS * COLS;
  localparam int KW = $clog2(NK);
  localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  logic [ROWS-1:0] r_sync1, r_sync2, r_rows;
  logic [DW-1:0]   r_dwell;
  logic [COLS-1:0] r_col, r_col_smp;
  logic            r_smp_valid;
  logic            w_last;
  logic [NK-1:0]   w_req, w_commit;
  logic [KW-1:0]   w_idx;
  logic            w_hit;
  assign w_last = r_dwell == DW'(SCAN_DIV - 1);
  assign col_select = r_col;
  assign any_pressed = |key_state;
  // sampled rows are debounced one cycle later, so events land one cycle after the sampling edge
  always_ff @(posedge clk)
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_rows <= '0;
      r_col_smp <= '0;
      r_smp_valid <= 1'b0;
      r_dwell <= '0;
      r_col <= COLS'(1);
      key_code <= '0;
      key_pressed <= 1'b0;
      key_released <= 1'b0;
    end else begin
      r_sync1 <= row_in;
      r_sync2 <= r_sync1;
      r_smp_valid <= w_last;
      if (w_last) begin
        r_rows <= r_sync2;
        r_col_smp <= r_col;
        r_col <= (r_col << 1) | (r_col >> (COLS - 1));
      end
      r_dwell <= w_last ? '0 : r_dwell + 1'b1;
      key_pressed <= w_hit && !key_state[w_idx];
      key_released <= w_hit && key_state[w_idx];
      if (w_hit) key_code <= w_idx;
    end
  // only one column is enabled at a time, so lowest key index equals lowest row
  always_comb begin
    w_idx = '0;
    for (int k = NK - 1; k >= 0; k--)
      if (w_req[k]) w_idx = KW'(k);
  end
  assign w_hit = |w_req;
  assign w_commit = w_hit ? (NK'(1) << w_idx) : '0;
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int K = key_index(r, c, COLS);
      key_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_key (
        .clk(clk),
        .rst(rst),
        .i_sample_en(r_smp_valid && r_col_smp[c]),
        .i_sample(r_rows[r]),
        .i_commit(w_commit[K]),
        .o_state(key_state[K]),
        .o_change_req(w_req[K])
      );
    end
  end
endmodule

// File: tb/tb_key_matrix_scanner.sv
// tb_key_matrix_scanner: directed checks of scan order, debounce, priority and reset
module tb_key_matrix_scanner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] row_in = '0;
  logic [3:0] col_select;
  logic [15:0] key_state;
  logic [3:0] key_code;
  logic key_pressed, key_released, any_pressed;
  logic [15:0] keys = '0;
  int errors = 0, checks = 0;
  int cyc = 0, n_press = 0, n_rel = 0, n_both = 0;
  int p_code[4], p_cyc[4], r_code[4];
  always #5 clk = ~clk;
  key_matrix_scanner #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
    .clk(clk),
    .rst(rst),
    .row_in(row_in),
    .col_select(col_select),
    .key_state(key_state),
    .key_code(key_code),
    .key_pressed(key_pressed),
    .key_released(key_released),
    .any_pressed(any_pressed)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [3:0] model();
    logic [3:0] v;
    for (int r = 0; r < 4; r++) v[r] = |(keys[r*4 +: 4] & col_select);
    return v;
  endfunction
  task automatic clear_events();
    n_press = 0;
    n_rel = 0;
    for (int i = 0; i < 4; i++) begin
      p_code[i] = -1;
      p_cyc[i] = -1;
      r_code[i] = -1;
    end
  endtask
  task automatic tick(input bit bounce, input int ph);
    @(negedge clk);
    cyc++;
    if (key_pressed) begin
      if (n_press < 4) begin
        p_code[n_press] = int'(key_code);
        p_cyc[n_press] = cyc;
      end
      n_press++;
    end
    if (key_released) begin
      if (n_rel < 4) r_code[n_rel] = int'(key_code);
      n_rel++;
    end
    if (key_pressed && key_released) n_both++;
    row_in = bounce ? {2'b00, ph[0] ^ ph[4], 1'b0} : model();
  endtask
  task automatic run(input int n, input bit bounce = 1'b0);
    for (int i = 0; i < n; i++) tick(bounce, i);
  endtask
  task automatic set_keys(input logic [15:0] v);
    keys = v;
    row_in = model();
  endtask
  task automatic wait_col(input logic [3:0] c);
    for (int i = 0; i < 64; i++) begin
      tick(1'b0, 0);
      if (col_select == c) return;
    end
    check("wait_col", 32'(col_select), 32'(c));
  endtask
  initial begin
    clear_events();
    run(3);
    check("rst col", 32'(col_select), 32'h1);
    check("rst state", 32'(key_state), 32'h0);
    check("rst code", 32'(key_code), 32'h0);
    check("rst pulses", {30'b0, key_pressed, key_released}, 32'h0);
    check("rst any", 32'(any_pressed), 32'h0);
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick(1'b0, 0);
      if (k == 3) check("scan k3", 32'(col_select), 32'h1);
      if (k == 4) check("scan k4", 32'(col_select), 32'h2);
      if (k == 8) check("scan k8", 32'(col_select), 32'h4);
      if (k == 12) check("scan k12", 32'(col_select), 32'h8);
      if (k == 16) check("scan k16", 32'(col_select), 32'h1);
    end
    check("idle events", 32'(n_press + n_rel), 32'h0);
    // single key press and release
    set_keys(16'h0040);
    run(48);
    check("k6 press n", 32'(n_press), 32'd1);
    check("k6 press code", 32'(p_code[0]), 32'd6);
    check("k6 state", 32'(key_state), 32'h0040);
    check("k6 any", 32'(any_pressed), 32'h1);
    check("k6 no rel", 32'(n_rel), 32'd0);
    clear_events();
    set_keys(16'h0000);
    run(48);
    check("k6 rel n", 32'(n_rel), 32'd1);
    check("k6 rel code", 32'(r_code[0]), 32'd6);
    check("k6 rel state", 32'(key_state), 32'h0);
    check("k6 rel any", 32'(any_pressed), 32'h0);
    // one-visit glitch on row 1, col 0
    clear_events();
    wait_col(4'h1);
    set_keys(16'h0010);
    wait_col(4'h2);
    set_keys(16'h0000);
    run(48);
    check("glitch events", 32'(n_press + n_rel), 32'd0);
    check("glitch state", 32'(key_state), 32'h0);
    // simultaneous rows 0 and 3 on col 1
    clear_events();
    wait_col(4'h1);
    set_keys(16'h2002);
    run(56);
    check("dual press n", 32'(n_press), 32'd2);
    check("dual first", 32'(p_code[0]), 32'd1);
    check("dual second", 32'(p_code[1]), 32'd13);
    check("dual spacing", 32'(p_cyc[1] - p_cyc[0]), 32'd16);
    check("dual state", 32'(key_state), 32'h2002);
    clear_events();
    set_keys(16'h0000);
    run(64);
    check("dual rel n", 32'(n_rel), 32'd2);
    check("dual rel first", 32'(r_code[0]), 32'd1);
    check("dual rel second", 32'(r_code[1]), 32'd13);
    check("dual rel state", 32'(key_state), 32'h0);
    // reset mid-dwell with key 6 held
    clear_events();
    set_keys(16'h0040);
    run(48);
    check("pre-rst press", 32'(n_press), 32'd1);
    run(2);
    rst = 1'b1;
    tick(1'b0, 0);
    check("mid rst col", 32'(col_select), 32'h1);
    check("mid rst state", 32'(key_state), 32'h0);
    check("mid rst code", 32'(key_code), 32'h0);
    check("mid rst pulses", {30'b0, key_pressed, key_released}, 32'h0);
    check("mid rst any", 32'(any_pressed), 32'h0);
    rst = 1'b0;
    clear_events();
    run(48);
    check("re-press n", 32'(n_press), 32'd1);
    check("re-press code", 32'(p_code[0]), 32'd6);
    check("re-press state", 32'(key_state), 32'h0040);
    set_keys(16'h0000);
    run(48);
    // bounce then stable press
    clear_events();
    run(48, 1'b1);
    check("bounce events", 32'(n_press + n_rel), 32'd0);
    check("bounce state", 32'(key_state), 32'h0);
    set_keys(16'h0040);
    run(48);
    check("settle press n", 32'(n_press), 32'd1);
    check("settle code", 32'(p_code[0]), 32'd6);
    check("settle state", 32'(key_state), 32'h0040);
    check("pulse exclusive", 32'(n_both), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
